multicycle_control: RTL

Main control state machine for the multicycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives the datapath enables and muxes, and produces the `alu_op`/`func` pair consumed by the ALU control decoder. It is the issuing end of that ALU-request interface and the requester on the unified instruction/data memory port.

---
 rtl/ctrl_pkg.sv | 68 ++++++
 rtl/ctrl_alu_req.sv | 52 +++++
 rtl/multicycle_control.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
//
// Shared constants for the multicycle RV32I main control FSM:
//   - state encodings (plain 4-bit localparams so older tools and waveform
//     viewers that predate SV enums can still decode them)
//   - RV32I major opcode values
//   - alu_op request codes sent to the ALU control decoder
//   - pc_src and wb_sel datapath mux encodings
//   - a helper that flags the reserved branch funct3 values
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (adds the TRAP state).
// ----------------------------------------------------------------------------
package ctrl_pkg;

    // FSM state encodings
    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_EXEC_R   = 4'd2;
    localparam logic [3:0] ST_EXEC_I   = 4'd3;
    localparam logic [3:0] ST_MEM_ADDR = 4'd4;
    localparam logic [3:0] ST_MEM_RD   = 4'd5;
    localparam logic [3:0] ST_MEM_WR   = 4'd6;
    localparam logic [3:0] ST_WB_ALU   = 4'd7;
    localparam logic [3:0] ST_WB_MEM   = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;
    localparam logic [3:0] ST_JUMP     = 4'd10;
    localparam logic [3:0] ST_JALR     = 4'd11;
    localparam logic [3:0] ST_LUI      = 4'd12;
    localparam logic [3:0] ST_AUIPC    = 4'd13;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic [3:0] ST_TRAP     = 4'd14;
`endif

    // RV32I major opcodes
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // alu_op request codes
    localparam logic [1:0] ALU_OP_IDLE = 2'b00;
    localparam logic [1:0] ALU_OP_ADD  = 2'b01;
    localparam logic [1:0] ALU_OP_RI   = 2'b10;
    localparam logic [1:0] ALU_OP_BR   = 2'b11;

    // PC source mux
    localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SRC_OLDIMM = 2'b01;
    localparam logic [1:0] PC_SRC_ALU    = 2'b10;

    // Register write-back mux
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;
    localparam logic [1:0] WB_SEL_IMM  = 2'b11;

    // funct3 010 and 011 have no branch meaning in RV32I
    function automatic logic is_bad_branch(input logic [2:0] funct3);
        return (funct3 == 3'b010) || (funct3 == 3'b011);
    endfunction

endpackage

// File: rtl/ctrl_alu_req.sv
// ----------------------------------------------------------------------------
// ctrl_alu_req
//
// Combinational generator of the alu_op/func request for the ALU control
// decoder, derived from the current FSM state and instruction fields.
//
// Ports:
//   state    in  4  current (registered) FSM state
//   funct3   in  3  IR[14:12]
//   funct7_5 in  1  IR[30]
//   alu_op   out 2  request class (idle/add/R-I/branch)
//   func     out 4  {funct7 bit, funct3}; zero unless alu_op is R-I or branch
// ----------------------------------------------------------------------------
module ctrl_alu_req
    import ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [1:0] alu_op,
    output logic [3:0] func
);

    always_comb begin
        alu_op = ALU_OP_IDLE;
        func   = 4'b0000;
        case (state)
            ST_EXEC_R: begin
                alu_op = ALU_OP_RI;
                func   = {funct7_5, funct3};
            end
            ST_EXEC_I: begin
                // IR[30] is part of the immediate for I-type, so it only
                // selects arithmetic shift on SRAI; ADDI must stay ADD.
                alu_op = ALU_OP_RI;
                func   = {(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
            end
            ST_MEM_ADDR, ST_JALR, ST_AUIPC: begin
                alu_op = ALU_OP_ADD;
            end
            ST_BRANCH: begin
                alu_op = ALU_OP_BR;
                func   = {1'b0, funct3};
            end
            default: begin
                alu_op = ALU_OP_IDLE;
                func   = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM of the multicycle RV32I core. Steps each instruction
// through fetch, decode, execute, memory and write-back, driving datapath
// enables/muxes, the ALU request and the unified memory port.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   opcode/funct3/funct7_5 instruction fields from IR
//   br_cond               ALU branch-condition flag (used in BRANCH)
//   mem_ready             memory completes the current request
//   mem_req, mem_we       memory request / write
//   ir_we, pc_we, pc_src  IR latch, PC write and PC source
//   rf_we, wb_sel         register write and write-back source
//   alu_src_a/b, alu_op, func  ALU operand muxes and request
//   illegal_instr         high while trapped on an illegal encoding
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN. When defined, illegal
// encodings lock the FSM in TRAP until reset; otherwise they act as a NOP.
// ----------------------------------------------------------------------------
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       br_cond,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic [3:0] func,
    output logic       illegal_instr
);

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic [3:0] ST_ILLEGAL = ST_TRAP;
`else
    localparam logic [3:0] ST_ILLEGAL = ST_FETCH;
`endif

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [1:0] req_alu_op;
    logic [3:0] req_func;

    ctrl_alu_req u_alu_req (
        .state    (state_q),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_op   (req_alu_op),
        .func     (req_func)
    );

    // Next-state and Moore/mem_ready-gated outputs. Everything defaults to
    // zero; reset forces all outputs low regardless of the current state.
    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_src        = PC_SRC_PLUS4;
        rf_we         = 1'b0;
        wb_sel        = WB_SEL_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = 1'b0;
        alu_op        = req_alu_op;
        func          = req_func;
        illegal_instr = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_REG:             state_d = ST_EXEC_R;
                    OP_IMM:             state_d = ST_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = ST_MEM_ADDR;
                    // Reserved branch funct3 is caught here so no PC write
                    // can happen for it.
                    OP_BRANCH:          state_d = is_bad_branch(funct3) ? ST_ILLEGAL : ST_BRANCH;
                    OP_JAL:             state_d = ST_JUMP;
                    OP_JALR:            state_d = ST_JALR;
                    OP_LUI:             state_d = ST_LUI;
                    OP_AUIPC:           state_d = ST_AUIPC;
                    default:            state_d = ST_ILLEGAL;
                endcase
            end
            ST_EXEC_R: begin
                state_d = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                alu_src_b = 1'b1;
                state_d   = ST_WB_ALU;
            end
            ST_MEM_ADDR: begin
                alu_src_b = 1'b1;
                state_d   = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_d = ST_WB_MEM;
                end
            end
            ST_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_WB_ALU: begin
                rf_we   = 1'b1;
                wb_sel  = WB_SEL_ALU;
                state_d = ST_FETCH;
            end
            ST_WB_MEM: begin
                rf_we   = 1'b1;
                wb_sel  = WB_SEL_MEM;
                state_d = ST_FETCH;
            end
            ST_BRANCH: begin
                pc_we   = br_cond;
                pc_src  = PC_SRC_OLDIMM;
                state_d = ST_FETCH;
            end
            ST_JUMP: begin
                rf_we   = 1'b1;
                wb_sel  = WB_SEL_LINK;
                pc_we   = 1'b1;
                pc_src  = PC_SRC_OLDIMM;
                state_d = ST_FETCH;
            end
            ST_JALR: begin
                alu_src_b = 1'b1;
                rf_we     = 1'b1;
                wb_sel    = WB_SEL_LINK;
                pc_we     = 1'b1;
                pc_src    = PC_SRC_ALU;
                state_d   = ST_FETCH;
            end
            ST_LUI: begin
                rf_we   = 1'b1;
                wb_sel  = WB_SEL_IMM;
                state_d = ST_FETCH;
            end
            ST_AUIPC: begin
                alu_src_a = 1'b1;
                alu_src_b = 1'b1;
                state_d   = ST_WB_ALU;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_TRAP: begin
                illegal_instr = 1'b1;
                state_d       = ST_TRAP;
            end
`endif
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (rst) begin
            state_d       = ST_FETCH;
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            ir_we         = 1'b0;
            pc_we         = 1'b0;
            pc_src        = PC_SRC_PLUS4;
            rf_we         = 1'b0;
            wb_sel        = WB_SEL_ALU;
            alu_src_a     = 1'b0;
            alu_src_b     = 1'b0;
            alu_op        = ALU_OP_IDLE;
            func          = 4'b0000;
            illegal_instr = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
